// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//
// Serial frame transmitter. A payload word accepted over a valid/ready
// handshake is sent on a single-bit line as: sync word (MSB first), payload
// (MSB first), an optional even-parity bit, then an idle-low gap.
//
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN
//   defined   -> PARITY state compiled in, one even-parity bit after payload
//   undefined -> DATA goes straight to GAP
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low
//   tx_valid     in   payload offered
//   tx_data      in   payload word, sampled on handshake only
//   tx_ready     out  block can accept a payload (state == IDLE)
//   serial_line  out  serial data, registered
//   busy         out  frame in progress, !tx_ready
//   frame_done   out  registered one-cycle pulse in the frame's last cycle
`timescale 1ns/1ps

module serial_frame_tx #(
    parameter int                  DATA_WIDTH   = 8,
    parameter int                  SYNC_LEN     = 7,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 7'b1001001,
    parameter int                  GAP_CYCLES   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  serial_line,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int SR_W    = SYNC_LEN + DATA_WIDTH;
    localparam int MAX_A   = (SYNC_LEN > DATA_WIDTH) ? SYNC_LEN : DATA_WIDTH;
    localparam int MAX_LEN = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic             GAP_ONE   = (GAP_CYCLES == 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP} state_t;
`endif

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [SR_W-1:0]     shreg_q, shreg_n;
    logic                line_n;
    logic                done_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic                parity_q, parity_n;
`endif

    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            serial_line <= 1'b0;
            frame_done  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            shreg_q     <= shreg_n;
            serial_line <= line_n;
            frame_done  <= done_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q    <= parity_n;
`endif
        end
    end

    // The line is registered, so each branch computes the bit for the
    // *next* cycle. Sync and payload share one shift register loaded with
    // {sync, payload}; its MSB is the next bit to emit. The counter holds the
    // cycles remaining in the current state and reloads on every entry.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        shreg_n  = shreg_q;
        line_n   = 1'b0;
        done_n   = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_n = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_n  = SYNC;
                    cnt_n    = SYNC_LOAD;
                    line_n   = SYNC_PATTERN[SYNC_LEN-1];
                    shreg_n  = {SYNC_PATTERN, tx_data} << 1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_n = ^tx_data;
`endif
                end
            end
            SYNC: begin
                // The exit edge already emits the first payload bit.
                line_n  = shreg_q[SR_W-1];
                shreg_n = shreg_q << 1;
                if (cnt_q == '0) begin
                    state_n = DATA;
                    cnt_n   = DATA_LOAD;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_n = PARITY;
                    cnt_n   = '0;
                    line_n  = parity_q;
`else
                    state_n = GAP;
                    cnt_n   = GAP_LOAD;
                    done_n  = GAP_ONE;
`endif
                end else begin
                    line_n  = shreg_q[SR_W-1];
                    shreg_n = shreg_q << 1;
                    cnt_n   = cnt_q - CNT_W'(1);
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                state_n = GAP;
                cnt_n   = GAP_LOAD;
                done_n  = GAP_ONE;
            end
`endif
            GAP: begin
                if (cnt_q == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n  = cnt_q - CNT_W'(1);
                    // Pulse lands in the final gap cycle.
                    done_n = (cnt_q == CNT_W'(1));
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
`timescale 1ns/1ps

module tb_serial_frame_tx;

    localparam int         DW   = 8;
    localparam int         SL   = 7;
    localparam int         GAP  = 2;
    localparam logic [6:0] SYNC = 7'b1001001;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int         P    = 1;
`else
    localparam int         P    = 0;
`endif
    // busy cycles per frame; handshake-to-handshake is FRAME+1
    localparam int         FRAME = SL + DW + P + GAP;
    localparam int         T     = 10;

    logic          clock;
    logic          reset;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          serial_line;
    logic          busy;
    logic          frame_done;

    serial_frame_tx dut (
        .clock       (clock),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .serial_line (serial_line),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one entry per expected busy cycle.
    typedef struct packed {
        logic line;
        logic done;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    task automatic push_frame(input logic [DW-1:0] d);
        for (int i = SL - 1; i >= 0; i--) q.push_back({SYNC[i], 1'b0});
        for (int i = DW - 1; i >= 0; i--) q.push_back({d[i], 1'b0});
        if (P == 1) q.push_back({^d, 1'b0});
        for (int i = 0; i < GAP; i++) q.push_back({1'b0, (i == GAP - 1) ? 1'b1 : 1'b0});
    endtask

    // Monitor: samples on the falling edge, pops one entry per busy cycle.
    always @(negedge clock) begin
        if (reset) begin
            chk("busy_vs_ready", busy, !tx_ready);
            if (busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame", busy, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("line", serial_line, mon_e.line);
                    chk("frame_done", frame_done, mon_e.done);
                end
            end else begin
                chk("idle_line", serial_line, 0);
                chk("idle_done", frame_done, 0);
            end
        end
    end

    // Loopback 1001001 detector on the same clock/reset.
    logic [6:0] det_hist;
    logic       det_match;
    int         det_cnt;
    time        det_t;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            det_hist  <= '0;
            det_match <= 1'b0;
        end else begin
            det_hist  <= {det_hist[5:0], serial_line};
            det_match <= ({det_hist[5:0], serial_line} == SYNC);
        end
    end

    always @(negedge clock) begin
        if (det_match) begin
            det_cnt++;
            if (det_cnt == 1) det_t = $time;
        end
    end

    time t_hs;

    // Called away from the rising edge; tx_ready only moves on that edge,
    // so seeing it high now means the next rising edge is the handshake.
    task automatic send(input logic [DW-1:0] d, input bit keep);
        int i;
        push_frame(d);
        tx_valid = 1'b1;
        tx_data  = d;
        i = 0;
        while (!tx_ready && i < 100) begin
            @(negedge clock);
            i++;
        end
        if (!tx_ready) begin
            chk("handshake_timeout", tx_ready, 1);
            q.delete();
            tx_valid = 1'b0;
        end else begin
            @(posedge clock);
            t_hs = $time;
            #1;
            if (!keep) tx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (!tx_ready && i < 100) begin
            @(negedge clock);
            i++;
        end
        if (!tx_ready) chk("idle_timeout", tx_ready, 1);
    endtask

    time t1, tr;

    initial begin
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        det_cnt  = 0;
        det_t    = 0;
        #3;
        chk("rst_line", serial_line, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        #24 reset = 1'b1;

        // A5: sync, payload, gap; ready drops at N+1 and returns at N+FRAME+1
        send(8'hA5, 1'b0);
        @(negedge clock);
        chk("ready_drop", tx_ready, 0);
        wait_idle();
        chk("ready_return", int'(($time - t_hs - T/2) / T), FRAME);

        // back-to-back with tx_valid held high
        send(8'h3C, 1'b1);
        t1 = t_hs;
        send(8'hFF, 1'b0);
        chk("b2b_interval", int'((t_hs - t1) / T), FRAME + 1);
        wait_idle();

        // tx_valid pulsed while busy is ignored
        send(8'hC3, 1'b0);
        repeat (5) @(negedge clock);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clock);
        tx_valid = 1'b0;
        wait_idle();
        repeat (25) @(negedge clock);
        chk("ignored_queue", q.size(), 0);

        // reset mid-DATA aborts the frame asynchronously
        send(8'h5A, 1'b0);
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort_line", serial_line, 0);
        chk("abort_ready", tx_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", frame_done, 0);
        q.delete();
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        tr = $time;
        send(8'h81, 1'b0);
        chk("post_reset_edge", int'((t_hs - tr) / T), 0);
        wait_idle();

        // parity payloads (odd / even weight)
        send(8'h07, 1'b0);
        wait_idle();
        send(8'h03, 1'b0);
        wait_idle();

        // loopback into the pattern detector
        repeat (3) @(negedge clock);
        det_cnt = 0;
        send(8'h00, 1'b0);
        wait_idle();
        repeat (3) @(negedge clock);
        chk("det_count", det_cnt, 1);
        chk("det_cycle", int'((det_t - t_hs - T/2) / T), 7);

        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter. Accepts a parallel payload word over a valid/ready handshake and drives a single-bit serial line with a fixed sync pattern, the payload, an optional parity bit and an idle gap. It is the transmit end of the serial link whose receive side runs the 1001001 pattern detector. It sits between the packet source logic and the serial pin.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1)
- SYNC_PATTERN, 7'b1001001, sync word, sent MSB first
- SYNC_LEN, 7, number of valid bits in SYNC_PATTERN
- GAP_CYCLES, 2, idle-low cycles after each frame (≥1)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low
- tx_valid  input  1  payload offered
- tx_data  input  DATA_WIDTH  payload, sampled on handshake only
- tx_ready  output  1  block can accept a payload
- serial_line  output  1  serial data, registered
- busy  output  1  frame in progress; equals !tx_ready
- frame_done  output  1  one-cycle pulse, last cycle of the frame

## Operation
- FSM states:
  - IDLE. Line low, tx_ready=1. On tx_valid&&tx_ready, latch tx_data into the shift register and go to SYNC.
  - SYNC. Emit SYNC_PATTERN MSB first over SYNC_LEN cycles, then go to DATA.
  - DATA. Emit the payload MSB first over DATA_WIDTH cycles, then go to PARITY if enabled, else to GAP.
  - PARITY. One cycle carrying the even parity bit (XOR of all payload bits), then go to GAP.
  - GAP. Line low for GAP_CYCLES cycles, then go to IDLE.
- A single down-counter is shared by all states. Its width is $clog2 of max(SYNC_LEN, DATA_WIDTH, GAP_CYCLES)+1. It reloads on every state entry.
- tx_ready is decoded from state==IDLE. No transfer is accepted while busy; tx_valid is ignored then. Neither tx_data nor tx_valid is required to stay stable after the handshake.
- Payload contents are not escaped. A payload that contains the sync pattern is the source's responsibility.
- Reset values: state IDLE, serial_line 0, tx_ready 1, busy 0, frame_done 0, counter and shift register 0.
- Reset asserted mid-frame: the frame is aborted immediately and asynchronously. The line goes low and frame_done does not pulse. After reset is released, the block is in IDLE and accepts data on the next edge.

## Timing
- Handshake at edge N. serial_line carries the sync bits during cycles N+1..N+SYNC_LEN and the payload bits during the next DATA_WIDTH cycles.
- Defaults, parity off:
  - Sync during N+1..N+7, values 1,0,0,1,0,0,1.
  - Data during N+8..N+15.
  - Gap during N+16..N+17.
  - frame_done high during N+17.
  - tx_ready high from N+18.
- Parity on: the parity bit is sent during N+16. Gap, frame_done and tx_ready each shift one cycle later.
- Minimum handshake-to-handshake interval: SYNC_LEN+DATA_WIDTH+P+GAP_CYCLES+1 cycles, where P=1 with parity and 0 without. With tx_valid held high, the next handshake occurs on the first IDLE cycle.
- All outputs except tx_ready/busy are flop outputs with no combinational path from inputs. tx_ready/busy are decoded from the state register only.

## Configuration
- SERIAL_FRAME_TX_PARITY_EN
  - Defined: the PARITY state is compiled in and one even-parity bit follows the payload.
  - Undefined: the PARITY state and its logic are absent, and DATA goes directly to GAP.

## Test plan
- Reset release, then tx_valid=1 with tx_data=8'hA5 → tx_ready drops at N+1. Line sequence from N+1 is 1001001 10100101 00. frame_done pulses once at N+17. tx_ready returns at N+18.
- tx_valid held high with 8'h3C then 8'hFF queued → second handshake exactly at N+18, and the second frame's sync starts at N+19 with no extra idle.
- tx_valid pulsed while busy at N+5 with 8'h00 → ignored. The frame completes with the original payload and no second frame follows.
- reset asserted at N+10 during DATA → serial_line=0 and tx_ready=1 immediately with no frame_done. After release, a new 8'h81 frame transmits correctly.
- SERIAL_FRAME_TX_PARITY_EN defined, tx_data=8'h07 → parity bit 1 at N+16, frame_done at N+18. With 8'h03 → parity bit 0.
- Loopback of serial_line into the 1001001 pattern detector (same clock/reset), tx_data=8'h00 → detector match high exactly one cycle, at N+8. No further match occurs during the data and gap cycles.
